// File: rtl/pipe_stage_latch.sv
// Inter-stage pipeline latch: NUM_FIELDS x DATA_W payload, valid/ready handshake,
// 2-entry skid buffer, synchronous flush-to-bubble and a saturating stall counter.
module pipe_stage_latch #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_FIELDS = 4,
  parameter int unsigned IR_FIELD   = 3,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [1:0]                   occupancy,
  output logic [CNT_W-1:0]             stall_cycles
);

  localparam int unsigned TOT_W  = NUM_FIELDS * DATA_W;
  localparam int unsigned IR_LSB = IR_FIELD * DATA_W;
  localparam logic [DATA_W-1:0] NOP_W  = DATA_W'(NOP_INSTR);
  localparam logic [TOT_W-1:0]  BUBBLE = TOT_W'(NOP_W) << IR_LSB;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TOT_W-1:0]   main_q, main_d;
  logic [TOT_W-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               in_fire, out_fire;

  // Handshake decodes come only from registered state (plus reset gating of in_ready).
  assign out_valid    = (state_q != EMPTY);
  assign in_ready     = (state_q != TWO) & clr;
  assign occupancy    = (state_q == TWO) ? 2'd2 : ((state_q == ONE) ? 2'd1 : 2'd0);
  assign out_data     = main_q;
  assign stall_cycles = stall_q;
  assign in_fire      = in_valid & in_ready;
  assign out_fire     = out_valid & out_ready;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  // Next state and datapath; flush overrides everything except the stall count.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end

    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = TWO;
          end else if (out_fire) begin
            main_d  = BUBBLE;
            state_d = EMPTY;
          end
        end
        TWO: begin
          // Skid always drains into main so ordering stays FIFO.
          if (out_fire) begin
            main_d  = skid_q;
            skid_d  = BUBBLE;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Scoreboard bench for pipe_stage_latch: default F/D configuration plus a
// 16-bit/2-field sweep instance with a 3-bit stall counter.
module tb_pipe_stage_latch;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [127:0] a_in_data, a_out_data;
  logic [1:0]   a_occ;
  logic [15:0]  a_stall;

  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0]  b_in_data, b_out_data;
  logic [1:0]   b_occ;
  logic [2:0]   b_stall;

  pipe_stage_latch dut_a (
    .clk(clk), .clr(clr), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cycles(a_stall)
  );

  pipe_stage_latch #(
    .DATA_W(16), .NUM_FIELDS(2), .IR_FIELD(0), .NOP_INSTR(32'h0000_0013), .CNT_W(3)
  ) dut_b (
    .clk(clk), .clr(clr), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cycles(b_stall)
  );

  int checks = 0;
  int failures = 0;
  logic [127:0] qa[$];
  logic [31:0]  qb[$];
  logic [127:0] exp_a;
  logic [31:0]  exp_b;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_a(input logic [31:0] tag);
    return {32'h0000_0100 + tag, 32'h1234_0000 ^ tag, 32'hCAFE_0000 | tag, tag + 32'h10};
  endfunction

  // Monitor pops on delivery; tracker records accepts (flush-cycle accepts are dropped).
  always @(negedge clk) begin
    if (clr && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_out_unexpected: got %h expected none", a_out_data);
      end else begin
        exp_a = qa.pop_front();
        check("a_out_data", a_out_data, exp_a);
      end
    end
    if (clr && a_in_valid && a_in_ready && !a_flush) qa.push_back(a_in_data);
  end

  always @(negedge clk) begin
    if (clr && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_out_unexpected: got %h expected none", b_out_data);
      end else begin
        exp_b = qb.pop_front();
        check("b_out_data", 128'(b_out_data), 128'(exp_b));
      end
    end
    if (clr && b_in_valid && b_in_ready && !b_flush) qb.push_back(b_in_data);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    step(); step();

    // Reset state
    check("rst_a_valid", 128'(a_out_valid), 128'(0));
    check("rst_a_occ", 128'(a_occ), 128'(0));
    check("rst_a_stall", 128'(a_stall), 128'(0));
    check("rst_a_in_ready", 128'(a_in_ready), 128'(0));
    check("rst_a_bubble", a_out_data, 128'h0);
    check("rst_b_bubble", 128'(b_out_data), 128'h0000_0013);
    check("rst_b_in_ready", 128'(b_in_ready), 128'(0));

    clr = 1'b1;
    #1;
    check("rel_a_in_ready", 128'(a_in_ready), 128'(1));
    check("rel_a_valid", 128'(a_out_valid), 128'(0));

    // Streaming at full throughput
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in_data = mk_a(32'(i));
      step();
      check("stream_a_valid", 128'(a_out_valid), 128'(1));
      check("stream_a_occ", 128'(a_occ), 128'(1));
      check("stream_a_stall", 128'(a_stall), 128'(0));
    end
    a_in_valid = 1'b0;
    step();
    check("stream_a_empty", 128'(a_occ), 128'(0));
    check("stream_a_drained", 128'(qa.size()), 128'(0));

    // Backpressure fill: A, B accepted, C held upstream
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = mk_a(32'hA);
    step();
    check("bp_occ1", 128'(a_occ), 128'(1));
    check("bp_stall0", 128'(a_stall), 128'(0));
    a_in_data = mk_a(32'hB);
    step();
    check("bp_occ2", 128'(a_occ), 128'(2));
    check("bp_in_ready0", 128'(a_in_ready), 128'(0));
    check("bp_stall1", 128'(a_stall), 128'(1));
    a_in_data = mk_a(32'hC);
    step();
    step();
    check("bp_stall3", 128'(a_stall), 128'(3));
    check("bp_head_a", a_out_data, mk_a(32'hA));
    check("bp_hold_occ2", 128'(a_occ), 128'(2));
    a_out_ready = 1'b1;
    step();
    check("bp_head_b", a_out_data, mk_a(32'hB));
    check("bp_occ_after_pop", 128'(a_occ), 128'(1));
    step();
    check("bp_head_c", a_out_data, mk_a(32'hC));
    a_in_valid = 1'b0;
    step();
    check("bp_empty", 128'(a_occ), 128'(0));
    check("bp_drained", 128'(qa.size()), 128'(0));
    check("bp_stall_final", 128'(a_stall), 128'(3));

    // Flush with two entries held while in_valid is high
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = mk_a(32'hD);
    step();
    a_in_data = mk_a(32'hE);
    step();
    check("fl_occ2", 128'(a_occ), 128'(2));
    a_flush   = 1'b1;
    a_in_data = mk_a(32'hF);
    step();
    qa.delete();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    check("fl_valid0", 128'(a_out_valid), 128'(0));
    check("fl_occ0", 128'(a_occ), 128'(0));
    check("fl_bubble", a_out_data, 128'h0);
    check("fl_stall5", 128'(a_stall), 128'(5));
    step();
    check("fl_no_ghost", 128'(a_out_valid), 128'(0));

    // Flush in ONE: head still delivered, concurrent accept discarded
    a_in_valid = 1'b1;
    a_in_data  = mk_a(32'h6);
    step();
    a_flush     = 1'b1;
    a_out_ready = 1'b1;
    a_in_data   = mk_a(32'h7);
    #1;
    check("fl1_in_ready", 128'(a_in_ready), 128'(1));
    step();
    check("fl1_delivered", 128'(qa.size()), 128'(0));
    check("fl1_occ0", 128'(a_occ), 128'(0));
    check("fl1_stall", 128'(a_stall), 128'(5));
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    step();
    check("fl1_no_ghost", 128'(a_out_valid), 128'(0));

    // Asynchronous reset while full and stalled
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = mk_a(32'h8);
    step();
    a_in_data = mk_a(32'h9);
    step();
    step();
    check("ar_pre_stall", 128'(a_stall), 128'(7));
    check("ar_pre_occ", 128'(a_occ), 128'(2));
    #2;
    clr = 1'b0;
    #1;
    check("ar_valid", 128'(a_out_valid), 128'(0));
    check("ar_occ", 128'(a_occ), 128'(0));
    check("ar_stall", 128'(a_stall), 128'(0));
    check("ar_in_ready", 128'(a_in_ready), 128'(0));
    check("ar_bubble", a_out_data, 128'h0);
    qa.delete();
    qb.delete();
    a_in_valid = 1'b0;
    step();
    clr = 1'b1;
    step();
    check("ar_post_occ", 128'(a_occ), 128'(0));

    // Sweep configuration: streaming
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_in_data = {16'(32'h50 + i), 16'(32'h100 + i)};
      step();
      check("b_stream_occ", 128'(b_occ), 128'(1));
      check("b_stream_stall", 128'(b_stall), 128'(0));
    end
    b_in_valid = 1'b0;
    step();
    check("b_stream_empty", 128'(b_occ), 128'(0));
    check("b_bubble", 128'(b_out_data), 128'h0000_0013);
    check("b_drained", 128'(qb.size()), 128'(0));

    // Stall counter saturation at 7
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 32'h0077_0042;
    step();
    b_in_valid = 1'b0;
    check("sat_start", 128'(b_stall), 128'(0));
    for (int k = 1; k <= 10; k++) begin
      step();
      check("sat_count", 128'(b_stall), 128'((k > 7) ? 7 : k));
    end
    b_out_ready = 1'b1;
    step();
    check("sat_hold", 128'(b_stall), 128'(7));
    check("sat_drained", 128'(qb.size()), 128'(0));
    check("sat_occ0", 128'(b_occ), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
